instr_fetch_buffer: RTL and testbench

//   Fetch stage upstream of decode and the immediate extender. Holds the fetch PC and issues

---
 rtl/instr_fetch_buffer.sv | 99 +++++++++
 tb/tb_instr_fetch_buffer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/instr_fetch_buffer.sv
// rtl/instr_fetch_buffer.sv - fetch PC, single-outstanding imem requests, PC-tagged instruction FIFO
module instr_fetch_buffer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_req_pc;
    logic          r_outstanding;
    logic          r_discard;
    logic [31:0]   r_fifo_instr [DEPTH];
    logic [31:0]   r_fifo_pc    [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic w_resp;
    logic w_push;
    logic w_pop;

    assign w_resp = imem_rvalid && r_outstanding;
    assign w_push = w_resp && !r_discard;
    assign w_pop  = instr_valid && instr_ready;

    // Issue only from registered state, so a response never finds the FIFO full.
    assign imem_req    = resetn && !redirect_valid && !r_outstanding && (r_count < CNT_FULL);
    assign imem_addr   = r_fetch_pc;
    assign instr_valid = (r_count != '0);
    assign instr       = r_fifo_instr[r_head];
    assign instr_pc    = r_fifo_pc[r_head];

    always_ff @(posedge clk) begin
        if (resetn && !redirect_valid && w_push) begin
            r_fifo_instr[r_tail] <= imem_rdata;
            r_fifo_pc[r_tail]    <= r_req_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_fetch_pc    <= RESET_PC;
            r_req_pc      <= RESET_PC;
            r_outstanding <= 1'b0;
            r_discard     <= 1'b0;
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
        end else if (redirect_valid) begin
            // A stale request still in flight must have its word thrown away on return.
            r_fetch_pc    <= {redirect_pc[31:2], 2'b00};
            r_discard     <= r_outstanding && !imem_rvalid;
            r_outstanding <= r_outstanding && !imem_rvalid;
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
        end else begin
            if (w_resp) begin
                r_outstanding <= 1'b0;
                r_discard     <= 1'b0;
            end
            if (imem_req) begin
                r_outstanding <= 1'b1;
                r_req_pc      <= r_fetch_pc;
                r_fetch_pc    <= r_fetch_pc + 32'd4;
            end
            if (w_push) begin
                r_tail <= r_tail + PTR_ONE;
            end
            if (w_pop) begin
                r_head <= r_head + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// tb/tb_instr_fetch_buffer.sv - randomized scoreboard bench for instr_fetch_buffer
module tb_instr_fetch_buffer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;
    localparam int          NCYC     = 4000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    always #5 clk = ~clk;

    instr_fetch_buffer #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_ready   (instr_ready)
    );

    int errors = 0;
    int checks = 0;
    int pops   = 0;
    int wraps  = 0;

    // Reference model: expected stream of PCs that decode should see, in order.
    logic [31:0] exp_q[$];
    logic [31:0] model_pc;
    int          epoch      = 0;
    bit          pend_valid = 0;
    logic [31:0] pend_addr;
    logic [31:0] pend_pc;
    int          pend_epoch;
    int          pend_cnt;
    bit          init       = 0;
    int          ready_mode = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares DUT outputs against the model mid-cycle, pops on consumption.
    always @(negedge clk) begin
        logic        exp_req;
        logic [31:0] pc;
        #1;
        if (init && resetn) begin
            exp_req = !redirect_valid && !pend_valid && (exp_q.size() < DEPTH);
            check("instr_valid", 32'(instr_valid), 32'(exp_q.size() != 0));
            check("imem_req", 32'(imem_req), 32'(exp_req));
            if (imem_req)
                check("imem_addr", imem_addr, model_pc);
            if (!redirect_valid && instr_valid && instr_ready && exp_q.size() != 0) begin
                pc = exp_q.pop_front();
                check("instr_pc", instr_pc, pc);
                check("instr", instr, mem_word(pc));
                pops++;
                if (pc == 32'hFFFF_FFFC) wraps++;
            end
        end else if (init) begin
            check("imem_req_in_reset", 32'(imem_req), 32'h0);
        end
    end

    initial begin
        resetn         = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        instr_ready    = 1'b0;
        model_pc       = RESET_PC;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            resetn         = !(cyc < 3 || $urandom_range(0, 299) == 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 3))
                0:       redirect_pc = 32'h0000_0103;
                1:       redirect_pc = 32'hFFFF_FFFC;
                2:       redirect_pc = 32'hFFFF_FFF9;
                default: redirect_pc = $urandom();
            endcase
            if ($urandom_range(0, 9) == 0) ready_mode = $urandom_range(0, 2);
            instr_ready = (ready_mode == 0) ? 1'b1 :
                          (ready_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
            if (pend_valid) begin
                pend_cnt--;
                imem_rvalid = (pend_cnt == 0);
                imem_rdata  = (pend_cnt == 0) ? mem_word(pend_addr) : $urandom();
            end else begin
                imem_rvalid = ($urandom_range(0, 7) == 0);
                imem_rdata  = $urandom();
            end
            #2;
            // Model the effect of the coming rising edge.
            if (!resetn) begin
                exp_q.delete();
                pend_valid = 0;
                model_pc   = RESET_PC;
                epoch++;
                init = 1;
            end else if (redirect_valid) begin
                exp_q.delete();
                model_pc = {redirect_pc[31:2], 2'b00};
                epoch++;
                if (imem_rvalid && pend_valid) pend_valid = 0;
            end else begin
                if (imem_rvalid && pend_valid) begin
                    if (pend_epoch == epoch) exp_q.push_back(pend_pc);
                    pend_valid = 0;
                end
                if (imem_req) begin
                    pend_valid = 1;
                    pend_addr  = imem_addr;
                    pend_pc    = model_pc;
                    pend_epoch = epoch;
                    pend_cnt   = $urandom_range(1, 3);
                    model_pc   = model_pc + 32'd4;
                end
            end
        end
        @(negedge clk);
        check("enough_pops", 32'(pops > 100), 32'h1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
